// File: rtl/arbitro_divisor.sv
// Round-robin arbiter/sequencer for the shared pipelined signed divider.
// Optional tag/done consistency check enabled by defining DIV_TAG_CHK_EN.
module arbitro_divisor #(
  parameter int AnchoDd  = 31,
  parameter int AnchoDv  = 15,
  parameter int AnchoQ   = 15,
  parameter int LATENCIA = 17,
  parameter int BUF_PROF = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqValid0,
  input  logic             reqValid1,
  output logic             reqReady0,
  output logic             reqReady1,
  input  logic [AnchoDd:0] dividend0,
  input  logic [AnchoDd:0] dividend1,
  input  logic [AnchoDv:0] divisor0,
  input  logic [AnchoDv:0] divisor1,
  output logic             respValid0,
  output logic             respValid1,
  input  logic             respReady0,
  input  logic             respReady1,
  output logic [AnchoQ:0]  respQuot0,
  output logic [AnchoQ:0]  respQuot1,
  output logic [AnchoQ:0]  respRem0,
  output logic [AnchoQ:0]  respRem1,
  output logic             respDivCero0,
  output logic             respDivCero1,
  output logic             pipeGo,
  output logic [AnchoDd:0] pipeDividend,
  output logic [AnchoDv:0] pipeDivisor,
  input  logic             pipeDone,
  input  logic [AnchoQ:0]  pipeQuot,
  input  logic [AnchoQ:0]  pipeRem,
  input  logic             pipeDivNoCero,
  output logic             errTag
);
  localparam int CW = $clog2(BUF_PROF + 1);
  localparam int PW = (BUF_PROF > 1) ? $clog2(BUF_PROF) : 1;
  localparam int DW = 2 * (AnchoQ + 1) + 1;

  logic [1:0]          reqValid, respReady;
  logic [1:0]          elig, grant, respValid, pop, wr;
  logic                rrPtr, pipeId;
  logic [LATENCIA-1:0] tagValid, tagId;
  logic                tailValid, tailId, wrEn;
  logic [DW-1:0]       wrData;
  logic [DW-1:0]       headData [2];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(BUF_PROF - 1)) ? '0 : p + PW'(1);
  endfunction

  assign reqValid  = {reqValid1, reqValid0};
  assign respReady = {respReady1, respReady0};

  // rrPtr==0 gives requester 0 priority on a tie
  assign grant[0] = elig[0] && (!elig[1] || !rrPtr);
  assign grant[1] = elig[1] && (!elig[0] || rrPtr);
  assign reqReady0 = grant[0];
  assign reqReady1 = grant[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipeGo       <= 1'b0;
      pipeDividend <= '0;
      pipeDivisor  <= '0;
      pipeId       <= 1'b0;
      rrPtr        <= 1'b0;
    end else begin
      pipeGo <= |grant;
      if (grant[1]) begin
        pipeDividend <= dividend1;
        pipeDivisor  <= divisor1;
        pipeId       <= 1'b1;
      end else if (grant[0]) begin
        pipeDividend <= dividend0;
        pipeDivisor  <= divisor0;
        pipeId       <= 1'b0;
      end
      if (&elig) rrPtr <= ~rrPtr;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tagValid <= '0;
      tagId    <= '0;
    end else begin
      tagValid[0] <= pipeGo;
      tagId[0]    <= pipeId;
      for (int i = 1; i < LATENCIA; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
    end
  end

  assign tailValid = tagValid[LATENCIA-1];
  assign tailId    = tagId[LATENCIA-1];
  assign wrEn      = pipeDone && tailValid;
  assign wr[0]     = wrEn && !tailId;
  assign wr[1]     = wrEn && tailId;
  assign wrData    = {pipeQuot, pipeRem, !pipeDivNoCero};

  for (genvar r = 0; r < 2; r++) begin : gResp
    logic [DW-1:0] mem [BUF_PROF];
    logic [PW-1:0] wrPtr, rdPtr;
    logic [CW-1:0] cnt, credit;

    assign elig[r]      = reqValid[r] && (credit != '0);
    assign respValid[r] = (cnt != '0);
    assign pop[r]       = respValid[r] && respReady[r];
    assign headData[r]  = respValid[r] ? mem[rdPtr] : '0;

    always_ff @(posedge clk) begin
      if (wr[r]) mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wrPtr  <= '0;
        rdPtr  <= '0;
        cnt    <= '0;
        credit <= CW'(BUF_PROF);
      end else begin
        if (wr[r])  wrPtr <= nextPtr(wrPtr);
        if (pop[r]) rdPtr <= nextPtr(rdPtr);
        unique case ({wr[r], pop[r]})
          2'b10:   cnt <= cnt + CW'(1);
          2'b01:   cnt <= cnt - CW'(1);
          default: cnt <= cnt;
        endcase
        // a credit is held from grant until its response is popped
        unique case ({grant[r], pop[r]})
          2'b10:   credit <= credit - CW'(1);
          2'b01:   credit <= credit + CW'(1);
          default: credit <= credit;
        endcase
      end
    end
  end

  assign respValid0 = respValid[0];
  assign respValid1 = respValid[1];
  assign {respQuot0, respRem0, respDivCero0} = headData[0];
  assign {respQuot1, respRem1, respDivCero1} = headData[1];

`ifdef DIV_TAG_CHK_EN
  always_ff @(posedge clk) begin
    if (!reset)                      errTag <= 1'b0;
    else if (pipeDone != tailValid) errTag <= 1'b1;
  end
`else
  assign errTag = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_divisor.sv
// Bench for arbitro_divisor: behavioural divider pipeline plus
// per-requester scoreboard queues and a small arbiter/credit model.
module tb_arbitro_divisor;
  localparam int LAT = 17;
  localparam int BUF = 2;

  logic        clk = 0;
  logic        reset = 0;
  logic        reqValid0 = 0, reqValid1 = 0;
  logic        reqReady0, reqReady1;
  logic [31:0] dividend0 = 0, dividend1 = 0;
  logic [15:0] divisor0 = 0, divisor1 = 0;
  logic        respValid0, respValid1;
  logic        respReady0 = 0, respReady1 = 0;
  logic [15:0] respQuot0, respQuot1, respRem0, respRem1;
  logic        respDivCero0, respDivCero1;
  logic        pipeGo;
  logic [31:0] pipeDividend;
  logic [15:0] pipeDivisor;
  logic        pipeDone;
  logic [15:0] pipeQuot, pipeRem;
  logic        pipeDivNoCero;
  logic        errTag;
  logic        forceDone = 0;

  int total = 0;
  int bad = 0;
  logic [32:0] exp0 [$];
  logic [32:0] exp1 [$];
  int   cr0 = BUF, cr1 = BUF;
  logic rr = 0;
  logic lastRdy0, lastRdy1;
`ifdef DIV_TAG_CHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  arbitro_divisor #(
    .AnchoDd(31), .AnchoDv(15), .AnchoQ(15),
    .LATENCIA(LAT), .BUF_PROF(BUF)
  ) dut (
    .clk(clk), .reset(reset),
    .reqValid0(reqValid0), .reqValid1(reqValid1),
    .reqReady0(reqReady0), .reqReady1(reqReady1),
    .dividend0(dividend0), .dividend1(dividend1),
    .divisor0(divisor0), .divisor1(divisor1),
    .respValid0(respValid0), .respValid1(respValid1),
    .respReady0(respReady0), .respReady1(respReady1),
    .respQuot0(respQuot0), .respQuot1(respQuot1),
    .respRem0(respRem0), .respRem1(respRem1),
    .respDivCero0(respDivCero0), .respDivCero1(respDivCero1),
    .pipeGo(pipeGo), .pipeDividend(pipeDividend),
    .pipeDivisor(pipeDivisor), .pipeDone(pipeDone),
    .pipeQuot(pipeQuot), .pipeRem(pipeRem),
    .pipeDivNoCero(pipeDivNoCero), .errTag(errTag)
  );

  always #5 clk = ~clk;

  // {quot, rem, divCero}; zero divisor yields all-ones quotient
  function automatic logic [32:0] refDiv(input logic [31:0] dd,
                                         input logic [15:0] dv);
    logic signed [31:0] a, b, q, r;
    if (dv == 16'd0) return {16'hFFFF, dd[15:0], 1'b1};
    a = dd;
    b = {{16{dv[15]}}, dv};
    q = a / b;
    r = a % b;
    return {q[15:0], r[15:0], 1'b0};
  endfunction

  logic [33:0] pipeSt [LAT];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) pipeSt[i] <= '0;
    end else begin
      pipeSt[0] <= {pipeGo, refDiv(pipeDividend, pipeDivisor)};
      for (int i = 1; i < LAT; i++) pipeSt[i] <= pipeSt[i-1];
    end
  end
  assign pipeDone      = pipeSt[LAT-1][33] | forceDone;
  assign pipeQuot      = pipeSt[LAT-1][32:17];
  assign pipeRem       = pipeSt[LAT-1][16:1];
  assign pipeDivNoCero = ~pipeSt[LAT-1][0];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    logic e0, e1, g0, g1, p0, p1;
    @(negedge clk);
    if (!reset) begin
      @(posedge clk); #1;
      exp0.delete(); exp1.delete();
      cr0 = BUF; cr1 = BUF; rr = 0;
      return;
    end
    e0 = reqValid0 && cr0 > 0;
    e1 = reqValid1 && cr1 > 0;
    g0 = e0 && (!e1 || !rr);
    g1 = e1 && (!e0 || rr);
    chk("rdy0", reqReady0, g0);
    chk("rdy1", reqReady1, g1);
    lastRdy0 = reqReady0;
    lastRdy1 = reqReady1;
    p0 = respValid0 && respReady0;
    p1 = respValid1 && respReady1;
    if (p0) begin
      chk("pend0", exp0.size() != 0, 1);
      if (exp0.size() != 0)
        chk("resp0", {respQuot0, respRem0, respDivCero0}, exp0.pop_front());
    end
    if (p1) begin
      chk("pend1", exp1.size() != 0, 1);
      if (exp1.size() != 0)
        chk("resp1", {respQuot1, respRem1, respDivCero1}, exp1.pop_front());
    end
    if (g0) exp0.push_back(refDiv(dividend0, divisor0));
    if (g1) exp1.push_back(refDiv(dividend1, divisor1));
    cr0 = cr0 - int'(g0) + int'(p0);
    cr1 = cr1 - int'(g1) + int'(p1);
    if (e0 && e1) rr = !rr;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    respReady0 = 1;
    respReady1 = 1;
    for (int k = 0; k < 80 && (exp0.size() + exp1.size()) != 0; k++) cycle();
    chk("drain", exp0.size() + exp1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n, g;
    reset = 0;
    cycle(); cycle();
    reset = 1;
    chk("rstGo", pipeGo, 0);
    chk("rstDd", pipeDividend, 0);
    chk("rstV0", respValid0, 0);
    chk("rstV1", respValid1, 0);
    chk("rstQ0", respQuot0, 0);
    chk("rstErr", errTag, 0);

    // single op 100/7 and latency
    reqValid0 = 1; dividend0 = 100; divisor0 = 7;
    cycle();
    reqValid0 = 0;
    chk("goAfterGrant", pipeGo, 1);
    chk("pipeDd", pipeDividend, 100);
    n = 0;
    while (!respValid0 && n < 60) begin cycle(); n++; end
    chk("latency", n, LAT + 1);
    chk("quot100", respQuot0, 14);
    chk("rem100", respRem0, 2);
    chk("dz100", respDivCero0, 0);
    respReady0 = 1;
    cycle();
    chk("popEmpty", respValid0, 0);

    // contention: alternate 0,1,0,1
    respReady1 = 1;
    reqValid0 = 1; reqValid1 = 1;
    for (int i = 0; i < 4; i++) begin
      dividend0 = 1000 + i; divisor0 = -16'sd3;
      dividend1 = -32'sd77 - i; divisor1 = 16'd5 + 16'(i);
      cycle();
      chk("contG0", lastRdy0, (i % 2) == 0);
      chk("contG1", lastRdy1, (i % 2) == 1);
      chk("contGo", pipeGo, 1);
    end
    reqValid0 = 0; reqValid1 = 0;
    cycle();
    chk("contIdle", pipeGo, 0);
    drain();

    // backpressure on requester 0
    respReady0 = 0; respReady1 = 1;
    reqValid0 = 1; reqValid1 = 1;
    g = 0;
    for (int i = 0; i < 25; i++) begin
      dividend0 = 32'(i * 37 + 5); divisor0 = 16'(i + 2);
      dividend1 = 32'(-i * 11); divisor1 = 16'(3);
      cycle();
      g += int'(lastRdy0);
    end
    chk("bpGrants0", g, BUF);
    chk("bpFull0", respValid0, 1);
    reqValid1 = 0;
    respReady0 = 1;
    cycle();
    chk("bpPopCycle", lastRdy0, 0);
    cycle();
    chk("bpResume", lastRdy0, 1);
    reqValid0 = 0;
    drain();

    // divide by zero
    respReady1 = 0;
    reqValid1 = 1; dividend1 = -32'sd50; divisor1 = 0;
    cycle();
    reqValid1 = 0;
    n = 0;
    while (!respValid1 && n < 60) begin cycle(); n++; end
    chk("dzLatency", n, LAT + 1);
    chk("dzFlag", respDivCero1, 1);
    chk("dzQuot", respQuot1, 16'hFFFF);
    chk("dzRem", respRem1, 16'hFFCE);
    drain();

    // reset mid-flight
    reqValid0 = 1; dividend0 = 9; divisor0 = 2;
    cycle();
    reqValid0 = 0; reqValid1 = 1; dividend1 = 8; divisor1 = 3;
    cycle();
    reqValid1 = 0; reqValid0 = 1; dividend0 = 21; divisor0 = 4;
    cycle();
    reqValid0 = 0;
    for (int i = 0; i < LAT / 2 - 3; i++) cycle();
    reset = 0;
    cycle();
    reset = 1;
    for (int i = 0; i < LAT + 4; i++) begin
      cycle();
      chk("mrV0", respValid0, 0);
      chk("mrV1", respValid1, 0);
      chk("mrErr", errTag, 0);
    end
    respReady0 = 0;
    reqValid0 = 1;
    g = 0;
    for (int i = 0; i < 3; i++) begin
      dividend0 = 32'(50 + i); divisor0 = 7;
      cycle();
      g += int'(lastRdy0);
    end
    chk("mrCredits", g, BUF);
    reqValid0 = 0;
    drain();

    // stray pipeDone with empty tag register
    forceDone = 1;
    cycle();
    forceDone = 0;
    chk("strayErr", errTag, ERR_EXP);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("strayV0", respValid0, 0);
      chk("strayV1", respValid1, 0);
      chk("errSticky", errTag, ERR_EXP);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
